// File: rtl/unpooler_pkg.sv
// Shared types and helpers for the nearest-neighbour unpooler.
// Counter widths derive from the instance's m and p through cnt_width().
package unpooler_pkg;

   typedef enum logic [0:0] {
      StFill   = 1'b0,
      StReplay = 1'b1
   } state_e;

   // Counter width for a modulo-n counter; never narrower than one bit.
   function automatic int cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/unpool_line_buf.sv
// Recirculating shift register holding one pooled input row.
// q is the oldest word; the parent chooses whether d is a new word or q itself.
module unpool_line_buf #(
   parameter int unsigned Depth = 4,
   parameter int unsigned N     = 16
) (
   input  logic         clk,
   input  logic         master_rst,
   input  logic         shift,
   input  logic [N-1:0] d,
   output logic [N-1:0] q
);

   logic [N-1:0] mem_q [Depth];
   logic [N-1:0] mem_d [Depth];

   always_comb begin
      for (int unsigned i = 0; i < Depth; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (shift) begin
         mem_d[0] = d;
         for (int unsigned i = 1; i < Depth; i++) begin
            mem_d[i] = mem_q[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge master_rst) begin
      if (!master_rst) begin
         for (int unsigned i = 0; i < Depth; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         mem_q <= mem_d;
      end
   end

   assign q = mem_q[Depth-1];

endmodule

// File: rtl/unpooler.sv
// Nearest-neighbour upsampler: each pooled word becomes a p x p block of the
// m x m output raster. The first row of a band streams from the input; the
// remaining p-1 rows are replayed from the line buffer.
module unpooler
   import unpooler_pkg::*;
#(
   parameter int unsigned m = 12,
   parameter int unsigned p = 3,
   parameter int unsigned N = 16
) (
   input  logic         clk,
   input  logic         master_rst,
   input  logic         ce,
   input  logic [N-1:0] data_in,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [N-1:0] data_out,
   output logic         valid_op,
   output logic         end_op
);

   localparam int unsigned D  = m / p;
   localparam int unsigned CW = cnt_width(D);
   localparam int unsigned RW = cnt_width(p);
   localparam logic [CW-1:0] ColLast = CW'(D - 1);
   localparam logic [RW-1:0] RepLast = RW'(p - 1);
   localparam bit Replay = (p > 1);

   state_e        state_q, state_d;
   logic [RW-1:0] rx_q, rx_d, ry_q, ry_d;
   logic [CW-1:0] col_q, col_d, band_q, band_d;
   logic [N-1:0]  hold_q, hold_d;
   logic          hold_v_q, hold_v_d;

   logic          lb_shift;
   logic [N-1:0]  lb_d, lb_q;

   logic last_rep, last_col, last_band, last_row, out_v, accept, in_fill;

   assign in_fill   = (state_q == StFill);
   assign last_rep  = (rx_q == RepLast);
   assign last_col  = (col_q == ColLast);
   assign last_band = (band_q == ColLast);
   assign last_row  = (ry_q == RepLast);
   assign out_v     = !in_fill || hold_v_q;

   // The final fill word of a band must not be followed by a new accept:
   // the next cycle belongs to the replay rows.
   assign in_ready = ce && in_fill && (!hold_v_q || (last_rep && !(Replay && last_col)));
   assign accept   = in_valid && in_ready;

   assign data_out = hold_q;
   assign valid_op = ce && out_v;
   assign end_op   = valid_op && last_rep && last_col && last_band && last_row;

   always_comb begin
      state_d  = state_q;
      rx_d     = rx_q;
      ry_d     = ry_q;
      col_d    = col_q;
      band_d   = band_q;
      hold_d   = hold_q;
      hold_v_d = hold_v_q;
      lb_shift = 1'b0;
      lb_d     = lb_q;

      if (ce && out_v) begin
         rx_d = last_rep ? '0 : rx_q + 1'b1;
         if (last_rep) begin
            col_d = last_col ? '0 : col_q + 1'b1;
            if (in_fill) begin
               hold_v_d = 1'b0;
               if (last_col) begin
                  if (Replay) begin
                     state_d  = StReplay;
                     ry_d     = RW'(1);
                     hold_d   = lb_q;
                     lb_shift = 1'b1;
                  end else begin
                     band_d = last_band ? '0 : band_q + 1'b1;
                  end
               end
            end else if (last_col && last_row) begin
               state_d = StFill;
               ry_d    = '0;
               band_d  = last_band ? '0 : band_q + 1'b1;
            end else begin
               // Fetch the next column one cycle ahead so replay stays bubble-free.
               if (last_col) begin
                  ry_d = ry_q + 1'b1;
               end
               hold_d   = lb_q;
               lb_shift = 1'b1;
            end
         end
      end

      if (accept) begin
         hold_d   = data_in;
         hold_v_d = 1'b1;
         rx_d     = '0;
         lb_shift = 1'b1;
         lb_d     = data_in;
      end
   end

   always_ff @(posedge clk or negedge master_rst) begin
      if (!master_rst) begin
         state_q  <= StFill;
         rx_q     <= '0;
         ry_q     <= '0;
         col_q    <= '0;
         band_q   <= '0;
         hold_q   <= '0;
         hold_v_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rx_q     <= rx_d;
         ry_q     <= ry_d;
         col_q    <= col_d;
         band_q   <= band_d;
         hold_q   <= hold_d;
         hold_v_q <= hold_v_d;
      end
   end

   unpool_line_buf #(
      .Depth(D),
      .N    (N)
   ) u_line_buf (
      .clk       (clk),
      .master_rst(master_rst),
      .shift     (lb_shift),
      .d         (lb_d),
      .q         (lb_q)
   );

endmodule

// File: tb/tb_unpooler.sv
// Self-checking bench for unpooler: m=12/p=3 instance for the main scenarios
// and an m=4/p=1 instance for the pass-through case.
module tb_unpooler;

   localparam int unsigned M  = 12;
   localparam int unsigned P  = 3;
   localparam int unsigned W  = 16;
   localparam int unsigned FR = M * M;
   localparam int unsigned M1 = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         master_rst = 1'b0;
   logic         ce = 1'b1, in_valid = 1'b0, in_ready, valid_op, end_op;
   logic [W-1:0] data_in = '0, data_out;
   logic         ce1 = 1'b1, in_valid1 = 1'b0, in_ready1, valid_op1, end_op1;
   logic [W-1:0] data_in1 = '0, data_out1;

   unpooler #(.m(M), .p(P), .N(W)) dut (
      .clk(clk), .master_rst(master_rst), .ce(ce), .data_in(data_in), .in_valid(in_valid),
      .in_ready(in_ready), .data_out(data_out), .valid_op(valid_op), .end_op(end_op)
   );

   unpooler #(.m(M1), .p(1), .N(W)) dut1 (
      .clk(clk), .master_rst(master_rst), .ce(ce1), .data_in(data_in1), .in_valid(in_valid1),
      .in_ready(in_ready1), .data_out(data_out1), .valid_op(valid_op1), .end_op(end_op1)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: bound expired (t=%0t)", name, $time);
   endtask

   // Output k of a frame lies at row k/mm, column k%mm; it copies the input word
   // at pooled row (row/pp), pooled column (col/pp).
   function automatic int model(int k, int mm, int pp, int base);
      return base + ((k / mm) / pp) * (mm / pp) + (k % mm) / pp;
   endfunction

   int cyc = 0;
   always begin
      @(posedge clk);
      cyc = cyc + 1;
   end

   // Frame bases queued by the stimulus, consumed by the compare process.
   int base_arr[16];
   int wr_ptr = 0;
   int rd_ptr = 0;

   int out_idx = 0, out_total = 0, frames_done = 0;
   bit after_end = 1'b0;
   int gap_cnt = 0, last_gap = -1, first_after = -1;
   logic [W-1:0] log0[FR];

   always begin
      @(negedge clk);
      if (!master_rst) begin
         out_idx   = 0;
         rd_ptr    = wr_ptr;
         after_end = 1'b0;
      end else if (!ce) begin
         chk("ce_low_valid", valid_op, 0);
         chk("ce_low_end", end_op, 0);
         chk("ce_low_ready", in_ready, 0);
      end else begin
         if (((out_idx / M) % P) != 0) begin
            chk("replay_ready", in_ready, 0);
            chk("replay_valid", valid_op, 1);
         end
         if (!valid_op) begin
            chk("idle_end", end_op, 0);
            if (after_end) gap_cnt++;
         end else if (rd_ptr == wr_ptr) begin
            chk("spurious_output", valid_op, 0);
         end else begin
            if (after_end) begin
               last_gap    = gap_cnt;
               first_after = int'(data_out);
               after_end   = 1'b0;
            end
            chk("data", data_out, model(out_idx, M, P, base_arr[rd_ptr % 16]));
            chk("end_op", end_op, out_idx == FR - 1);
            if (frames_done == 0) log0[out_idx] = data_out;
            out_total++;
            out_idx++;
            if (out_idx == FR) begin
               out_idx = 0;
               frames_done++;
               rd_ptr++;
               after_end = 1'b1;
               gap_cnt   = 0;
            end
         end
      end
   end

   int idx1 = 0, ends1 = 0, val_cyc1 = -1, acc_cyc1 = -2;
   bit started1 = 1'b0;
   logic [W-1:0] log1[M1*M1];

   always begin
      @(negedge clk);
      if (!master_rst) begin
         idx1     = 0;
         started1 = 1'b0;
      end else if (valid_op1) begin
         if (!started1) begin
            started1 = 1'b1;
            val_cyc1 = cyc;
         end
         chk("p1_data", data_out1, model(idx1, M1, 1, 7));
         chk("p1_end", end_op1, idx1 == M1 * M1 - 1);
         log1[idx1] = data_out1;
         idx1++;
         if (idx1 == M1 * M1) begin
            idx1     = 0;
            started1 = 1'b0;
            ends1++;
         end
      end else if (started1) begin
         chk("p1_bubble", valid_op1, 1);
      end
   end

   bit abort = 1'b0;

   task automatic send_word(input int w);
      int t = 0;
      in_valid = 1'b1;
      data_in  = W'(w);
      @(negedge clk);
      while (!in_ready && !abort) begin
         if (t++ == 3000) begin
            fail("ready_wait");
            break;
         end
         @(negedge clk);
      end
      if (!abort && in_ready) @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input int base, input int maxgap);
      for (int i = 0; i < 16; i++) begin
         if (abort) break;
         repeat ((maxgap > 0) ? $urandom_range(0, maxgap) : 0) begin
            @(posedge clk);
            #1;
         end
         send_word(base + i);
      end
   endtask

   task automatic push_base(input int base);
      base_arr[wr_ptr % 16] = base;
      wr_ptr++;
   endtask

   task automatic wait_frames(input int n);
      int t = 0;
      while (frames_done < n && t < 5000) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (t >= 5000) fail("wait_frames");
   endtask

   task automatic wait_outputs(input int n);
      int t = 0;
      while (out_total < n && t < 5000) begin
         @(posedge clk);
         #1;
         t++;
      end
      if (t >= 5000) fail("wait_outputs");
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int f0, t0;
      logic [W-1:0] held;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_data_out", data_out, 0);
      chk("rst_valid_op", valid_op, 0);
      chk("rst_end_op", end_op, 0);
      chk("rst_p1_data_out", data_out1, 0);
      chk("rst_p1_valid_op", valid_op1, 0);
      @(posedge clk);
      #1;
      master_rst = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", in_ready, 1);
      @(posedge clk);
      #1;
      ce = 1'b0;
      @(negedge clk);
      chk("ready_ce_low", in_ready, 0);
      @(posedge clk);
      #1;
      ce = 1'b1;

      // Ramp
      push_base(0);
      send_frame(0, 0);
      wait_frames(1);
      chk("ramp_total", out_total, FR);
      chk("ramp_out0", log0[0], 0);
      chk("ramp_out3", log0[3], 1);
      chk("ramp_out11", log0[11], 3);
      chk("ramp_row1_start", log0[12], 0);
      chk("ramp_row2_end", log0[35], 3);
      chk("ramp_row3_start", log0[36], 4);
      chk("ramp_last", log0[FR-1], 15);

      // Source bubbles
      push_base(0);
      send_frame(0, 2);
      wait_frames(2);

      // ce stall mid-replay
      push_base(200);
      t0 = out_total;
      fork
         send_frame(200, 0);
         begin
            wait_outputs(t0 + 20);
            held = data_out;
            ce   = 1'b0;
            repeat (5) begin
               @(negedge clk);
               chk("stall_hold", data_out, held);
            end
            @(posedge clk);
            #1;
            ce = 1'b1;
         end
      join
      wait_frames(3);
      chk("stall_total", out_total, 3 * FR);

      // Reset mid-frame
      push_base(0);
      t0 = out_total;
      fork
         send_frame(0, 0);
         begin
            wait_outputs(t0 + 50);
            abort      = 1'b1;
            master_rst = 1'b0;
         end
      join
      @(negedge clk);
      chk("midrst_data_out", data_out, 0);
      chk("midrst_valid_op", valid_op, 0);
      chk("midrst_end_op", end_op, 0);
      repeat (2) @(posedge clk);
      #1;
      master_rst = 1'b1;
      abort      = 1'b0;
      f0 = frames_done;
      t0 = out_total;
      push_base(0);
      send_frame(0, 0);
      wait_frames(f0 + 1);
      chk("midrst_frames", frames_done - f0, 1);
      chk("midrst_outputs", out_total - t0, FR);

      // Back-to-back frames
      push_base(0);
      push_base(100);
      send_frame(0, 0);
      send_frame(100, 0);
      wait_frames(f0 + 3);
      chk("b2b_gap", last_gap, 1);
      chk("b2b_first", first_after, 100);

      // p=1 pass-through
      for (int i = 0; i < 16; i++) begin
         int t = 0;
         in_valid1 = 1'b1;
         data_in1  = W'(7 + i);
         @(negedge clk);
         while (!in_ready1 && t < 100) begin
            t++;
            @(negedge clk);
         end
         if (t >= 100) fail("p1_ready_wait");
         @(posedge clk);
         if (i == 0) acc_cyc1 = cyc;
         #1;
         in_valid1 = 1'b0;
      end
      repeat (4) @(posedge clk);
      #1;
      // cyc advances at each edge, so the cycle right after the accepting edge
      // carries the same count as that edge.
      chk("p1_latency", val_cyc1, acc_cyc1);
      chk("p1_frames", ends1, 1);
      chk("p1_first", log1[0], 7);
      chk("p1_last", log1[M1*M1-1], 22);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
